// File: rtl/signal_pwm_pkg.sv
// Shared definitions for the PWM H-bridge driver: command word layout,
// FSM state encoding and drive-mode encoding.
package signal_pwm_pkg;

    localparam int CMD_EN    = 15;
    localparam int CMD_DIR   = 14;
    localparam int CMD_BRAKE = 13;
    localparam int CMD_RSVD  = 12;
    localparam int DUTY_W    = 12;

    localparam logic [DUTY_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        COAST = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD   = 2'd0,
        REV   = 2'd1,
        BRAKE = 2'd2
    } mode_t;

    // Brake dominates direction.
    function automatic mode_t cmd_mode(input logic [15:0] c);
        if (c[CMD_BRAKE])
            return BRAKE;
        else if (c[CMD_DIR])
            return REV;
        else
            return FWD;
    endfunction

    function automatic logic [15:0] cmd_clean(input logic [15:0] c);
        logic [15:0] r;
        r           = c;
        r[CMD_RSVD] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/signal_pwm_driver_timebase.sv
// PWM timebase: prescaler producing a step strobe and a free-running 12-bit
// period counter, both clearable synchronously.
module pwm_timebase
    import signal_pwm_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    output logic              step,
    output logic [DUTY_W-1:0] cnt,
    output logic              period_end
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    assign step       = (pre_q == PRE_MAX);
    assign period_end = step && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pre_q <= '0;
            cnt   <= '0;
        end else begin
            if (step) begin
                pre_q <= '0;
                cnt   <= cnt + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/signal_pwm_driver.sv
// One H-bridge channel driven from the PIO command word, with shadowed
// period-boundary updates, dead time on mode changes and immediate coast.
module signal_pwm_driver
    import signal_pwm_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int DEADTIME = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cmd,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic        period_start,
    output logic [1:0]  state,
    output logic [15:0] active_cmd
);

    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME - 1);

    state_t            state_q, state_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [DW-1:0]     dead_q, dead_d;
    logic              start_d;
    logic              tb_clear;
    logic              tb_step;
    logic              tb_period_end;
    logic [DUTY_W-1:0] cnt;
    logic              pwm_raw;
    logic              pwm_a_d, pwm_b_d;
    mode_t             cur_mode;

    pwm_timebase #(
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .clk       (clk),
        .reset     (reset),
        .clear     (tb_clear),
        .step      (tb_step),
        .cnt       (cnt),
        .period_end(tb_period_end)
    );

    assign pwm_raw    = (cnt < shadow_q[DUTY_W-1:0]);
    assign cur_mode   = cmd_mode(shadow_q);
    assign state      = state_q;
    assign active_cmd = shadow_q;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        dead_d   = dead_q;
        start_d  = 1'b0;
        tb_clear = 1'b0;
        case (state_q)
            COAST: begin
                if (cmd[CMD_EN]) begin
                    shadow_d = cmd_clean(cmd);
                    dead_d   = DEAD_LOAD;
                    state_d  = DEAD;
                end
            end
            DEAD: begin
                if (!cmd[CMD_EN]) begin
                    state_d = COAST;
                end else if (dead_q == '0) begin
                    // Mode stays as latched on entry; only duty is refreshed.
                    shadow_d[DUTY_W-1:0] = cmd[DUTY_W-1:0];
                    tb_clear = 1'b1;
                    start_d  = 1'b1;
                    state_d  = RUN;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            RUN: begin
                if (!cmd[CMD_EN]) begin
                    state_d = COAST;
                end else if (tb_step && tb_period_end) begin
                    shadow_d = cmd_clean(cmd);
                    start_d  = 1'b1;
                    if (cmd_mode(cmd) != cur_mode) begin
                        dead_d  = DEAD_LOAD;
                        state_d = DEAD;
                    end
                end
            end
            default: state_d = COAST;
        endcase
    end

    always_comb begin
        pwm_a_d = 1'b0;
        pwm_b_d = 1'b0;
        if (state_q == RUN) begin
            case (cur_mode)
                FWD:     pwm_a_d = pwm_raw;
                REV:     pwm_b_d = pwm_raw;
                BRAKE: begin
                    pwm_a_d = 1'b1;
                    pwm_b_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COAST;
            shadow_q     <= '0;
            dead_q       <= '0;
            pwm_a        <= 1'b0;
            pwm_b        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            dead_q       <= dead_d;
            pwm_a        <= pwm_a_d;
            pwm_b        <= pwm_b_d;
            period_start <= start_d;
        end
    end

endmodule

// File: tb/tb_signal_pwm_driver.sv
// Self-checking bench for signal_pwm_driver: table of per-period commands with
// a scoreboard of expected duty counts, plus hand-written corner sequences.
module tb_signal_pwm_driver;
    import signal_pwm_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cmd;

    logic        pwm_a, pwm_b, period_start;
    logic [1:0]  state;
    logic [15:0] active_cmd;

    logic        pwm_a_3, pwm_b_3, period_start_3;
    logic [1:0]  state_3;
    logic [15:0] active_cmd_3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    signal_pwm_driver #(.PRESCALE(1), .DEADTIME(4)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .period_start(period_start),
        .state       (state),
        .active_cmd  (active_cmd)
    );

    signal_pwm_driver #(.PRESCALE(3), .DEADTIME(4)) u_dut_p3 (
        .clk         (clk),
        .reset       (reset),
        .cmd         (cmd),
        .pwm_a       (pwm_a_3),
        .pwm_b       (pwm_b_3),
        .period_start(period_start_3),
        .state       (state_3),
        .active_cmd  (active_cmd_3)
    );

    typedef struct packed {
        logic [15:0] shadow;
        logic [12:0] ha;
        logic [12:0] hb;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [15:0] next_cmd;
        int          change_at;
        logic [15:0] exp_active;
        int          exp_a;
        int          exp_b;
        bit          exp_dead;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ps(input bit p3, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p3 ? period_start_3 : period_start) && n < budget);
        if (!(p3 ? period_start_3 : period_start)) begin
            checks++;
            failures++;
            $display("FAIL %s timeout after %0d cycles", name, n);
        end
    endtask

    initial begin
        exp_t e;
        logic [15:0] next_shadow;

        // next_cmd applied mid-period; exp_* describe the period that follows.
        vecs[0] = '{16'h8400, 100, 16'h8400, 1024, 0,    1'b0};
        vecs[1] = '{16'hC800, 50,  16'hC800, 0,    2048, 1'b1};
        vecs[2] = '{16'h8FFF, 10,  16'h8FFF, 4095, 0,    1'b1};
        vecs[3] = '{16'h9000, 10,  16'h8000, 0,    0,    1'b0};
        vecs[4] = '{16'hA000, 10,  16'hA000, 4096, 4096, 1'b1};
        vecs[5] = '{16'h8800, 10,  16'h8800, 2048, 0,    1'b1};
        vecs[6] = '{16'h8800, -1,  16'h8800, 2048, 0,    1'b0};

        reset = 1'b1;
        cmd   = 16'h8800;
        repeat (3) begin
            @(negedge clk);
            check("reset_state", 32'(state), 32'd0);
            check("reset_pwm", 32'({pwm_a, pwm_b}), 32'd0);
            check("reset_active", 32'(active_cmd), 32'd0);
            check("reset_pstart", 32'(period_start), 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("enable_state_%0d", i), 32'(state), (i < 4) ? 32'd1 : 32'd2);
            check($sformatf("enable_pstart_%0d", i), 32'(period_start), (i == 4) ? 32'd1 : 32'd0);
            if (i == 0) check("enable_active", 32'(active_cmd), 32'h8800);
        end

        exp_q.push_back('{16'h8800, 13'd2048, 13'd0});

        for (int i = 0; i < 7; i++) begin
            int ha, hb, early_ps;
            ha = 0;
            hb = 0;
            early_ps = 0;
            for (int j = 1; j <= 4096; j++) begin
                @(negedge clk);
                ha += int'(pwm_a);
                hb += int'(pwm_b);
                if (j < 4096 && period_start) early_ps++;
                if (j == vecs[i].change_at) begin
                    cmd = vecs[i].next_cmd;
                    exp_q.push_back('{vecs[i].exp_active, 13'(vecs[i].exp_a), 13'(vecs[i].exp_b)});
                end
            end
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty window=%0d", i);
                continue;
            end
            e = exp_q.pop_front();
            next_shadow = (exp_q.size() > 0) ? exp_q[0].shadow : e.shadow;
            check($sformatf("win%0d_high_a", i), 32'(ha), 32'(e.ha));
            check($sformatf("win%0d_high_b", i), 32'(hb), 32'(e.hb));
            check($sformatf("win%0d_early_pstart", i), 32'(early_ps), 32'd0);
            check($sformatf("win%0d_end_pstart", i), 32'(period_start), 32'd1);
            check($sformatf("win%0d_active", i), 32'(active_cmd), 32'(next_shadow));
            check($sformatf("win%0d_end_state", i), 32'(state), vecs[i].exp_dead ? 32'd1 : 32'd2);
            if (vecs[i].exp_dead) begin
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    check($sformatf("win%0d_dead_pwm_%0d", i, k), 32'({pwm_a, pwm_b}), 32'd0);
                    check($sformatf("win%0d_dead_state_%0d", i, k), 32'(state), (k < 4) ? 32'd1 : 32'd2);
                end
                check($sformatf("win%0d_dead_exit_pstart", i), 32'(period_start), 32'd1);
            end
        end

        // Immediate disable at cnt = 10.
        repeat (10) @(negedge clk);
        cmd = 16'h0800;
        @(negedge clk);
        check("disable_state", 32'(state), 32'd0);
        check("disable_pstart", 32'(period_start), 32'd0);
        @(negedge clk);
        check("disable_pwm", 32'({pwm_a, pwm_b}), 32'd0);
        begin
            int bad;
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (pwm_a || pwm_b || period_start || state != 2'd0) bad++;
            end
            check("disable_hold", 32'(bad), 32'd0);
        end

        // Prescaled instance: period length and duty in clk cycles.
        cmd = 16'h8800;
        wait_ps(1'b1, 100, "p3_first_pstart");
        begin
            int n, h;
            n = 0;
            h = 0;
            do begin
                @(negedge clk);
                n++;
                h += int'(pwm_a_3);
            end while (!period_start_3 && n < 13000);
            check("p3_period", 32'(n), 32'd12288);
            check("p3_high_a", 32'(h), 32'd6144);
        end

        // Disable arriving exactly on the period end edge.
        wait_ps(1'b0, 5000, "simul_pstart");
        repeat (4095) @(negedge clk);
        cmd = 16'h0400;
        @(negedge clk);
        check("simul_state", 32'(state), 32'd0);
        check("simul_pstart", 32'(period_start), 32'd0);
        check("simul_active", 32'(active_cmd), 32'h8800);

        // Reset in the middle of RUN.
        cmd = 16'hA000;
        wait_ps(1'b0, 50, "midreset_pstart");
        repeat (5) @(negedge clk);
        check("midreset_pre_pwm", 32'({pwm_a, pwm_b}), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_state", 32'(state), 32'd0);
        check("midreset_pwm", 32'({pwm_a, pwm_b}), 32'd0);
        check("midreset_active", 32'(active_cmd), 32'd0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signal_pwm_driver.md
Name: signal_pwm_driver

Overview:
- Downstream consumer of the 16-bit PIO command word (signal_out out_port) that the Nios writes over Avalon.
- Decodes the word into enable, direction, brake and a 12-bit duty cycle.
- Drives one H-bridge channel (pwm_a / pwm_b) with glitch-free shadow updates, dead-time insertion on mode changes, and immediate coast on disable.

Parameters:
- PRESCALE, 4: clk cycles per PWM counter step; legal range is 1 or more.
- DEADTIME, 50: clk cycles with both outputs low on any drive-mode change; legal range is 1 or more.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd  in  16  command word from the PIO, same clock domain.
  - bit 15: en.
  - bit 14: dir (0 = A, 1 = B).
  - bit 13: brake.
  - bit 12: reserved, ignored.
  - bits 11:0: duty.
- pwm_a  out  1  bridge side A drive, registered.
- pwm_b  out  1  bridge side B drive, registered.
- period_start  out  1  one-clk pulse when a new PWM period begins and the shadow is loaded.
- state  out  2  current state: 0 = COAST, 1 = DEAD, 2 = RUN.
- active_cmd  out  16  shadow register in use; reserved bit reads 0.

Behaviour:
- Reset, applied on the clk edge while reset = 1:
  - State goes to COAST.
  - Prescaler, period counter, dead counter and shadow all clear to 0.
  - pwm_a, pwm_b, period_start and active_cmd all clear to 0.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - step = 1 when it equals PRESCALE-1, then it wraps to 0.
  - With PRESCALE = 1, step = 1 every cycle.
- Period counter cnt:
  - 12-bit, advances by 1 on step and wraps 4095 -> 0.
  - One period = 4096 steps.
  - pwm_raw = (cnt < shadow duty), unsigned compare.
  - duty 0 gives a constant low; duty 0xFFF gives high for 4095 of 4096 steps.
- Drive mode, derived from the shadow:
  - FWD: brake = 0, dir = 0. pwm_a = pwm_raw, pwm_b = 0.
  - REV: brake = 0, dir = 1. pwm_a = 0, pwm_b = pwm_raw.
  - BRAKE: brake = 1, dir ignored. pwm_a = pwm_b = 1.
- State machine, transitions taken on clk edges:
  - COAST:
    - Outputs are low.
    - If cmd.en = 1: latch the full cmd into the shadow, load dead counter = DEADTIME-1, go to DEAD.
  - DEAD:
    - Outputs are low.
    - If cmd.en = 0: go to COAST, overriding everything else.
    - Else if dead counter = 0:
      - Re-latch duty only from cmd; the mode latched on DEAD entry is kept.
      - Clear cnt and prescaler, pulse period_start, go to RUN.
    - Else decrement the dead counter.
  - RUN:
    - Outputs follow the drive mode.
    - If cmd.en = 0: go to COAST.
    - Else at period end (step = 1 and cnt = 4095):
      - Latch cmd and pulse period_start.
      - If the new mode differs from the current mode, go to DEAD with dead counter = DEADTIME-1.
      - Otherwise stay in RUN, with cnt wrapping to 0.
- Latency:
  - Outputs are registered, one cycle after the state or counter value that drives them.
  - en = 0 sampled at edge N gives pwm_a = pwm_b = 0 after edge N+1.
- Duty or mode written mid-period has no effect until the next period end. The one exception is en = 0, which acts immediately.
- A mode change during DEAD is not re-evaluated at DEAD exit. It is handled at the next period end.
- Simultaneous events: at a period end with en = 0, COAST wins and there is no period_start.
- Reset mid-operation takes precedence over all of the above and forces COAST and zero outputs on that edge.

Decomposition:
- Package signal_pwm_pkg holds:
  - Bit-index constants: CMD_EN = 15, CMD_DIR = 14, CMD_BRAKE = 13, DUTY_W = 12.
  - State encoding constants: COAST = 0, DEAD = 1, RUN = 2.
  - Mode encoding: FWD, REV, BRAKE.
- One natural sub-module, pwm_timebase: prescaler plus 12-bit period counter with a sync clear. Its outputs are step, cnt and period_end.
- The FSM, shadow register and output mux stay in the top level.

Test Plan:
- Reset and enable:
  - Stimulus: PRESCALE = 1, DEADTIME = 4. Assert reset for 3 cycles with cmd = 0x8800, then release.
  - Required: during reset, pwm_a = pwm_b = 0 and state = 0.
  - Required after release: state goes 1 for 4 cycles, then 2, with period_start pulsing once.
- Forward PWM: with cmd = 0x8800 in RUN, pwm_a is high for exactly 2048 of every 4096 clk and pwm_b stays 0.
- Deferred duty update:
  - Stimulus: change cmd 0x8800 -> 0x8400 at cnt = 100.
  - Required: the current period still has 2048 high cycles; the following period has 1024 high cycles; active_cmd updates at period_start.
- Direction change:
  - Stimulus: change cmd 0x8800 -> 0xC800.
  - Required: at period end both outputs are low for 4 cycles, then pwm_b is high 2048 of 4096 and pwm_a stays 0.
- Immediate disable: cmd -> 0x0800 at cnt = 10 in RUN makes pwm_a = 0 after one edge, state = 0, and no period_start.
- Brake and duty boundaries:
  - 0xA000: after DEAD, pwm_a = pwm_b = 1.
  - 0x8000: pwm_a is constantly 0.
  - 0x8FFF: pwm_a is high for 4095 of 4096 cycles.
  - With PRESCALE = 3: the period measures 12288 clk.
